// File: rtl/drive_cmd_pkg.sv
// Shared definitions for the drive command arbiter: command bit indices,
// UART byte constants, FSM state encoding and small helper functions.
package drive_cmd_pkg;

   localparam int unsigned NUM_REQ     = 3;
   localparam int unsigned CMD_W       = 6;
   localparam int unsigned IDX_W       = 2;

   // Command bit positions inside the 6-bit motion command
   localparam int unsigned CMD_FWD     = 0;
   localparam int unsigned CMD_BWD     = 1;
   localparam int unsigned CMD_LEFT    = 2;
   localparam int unsigned CMD_RIGHT   = 3;
   localparam int unsigned CMD_PLACE   = 4;
   localparam int unsigned CMD_DESTROY = 5;

   localparam logic [1:0] CMD_HDR   = 2'b10;
   localparam logic [7:0] STOP_BYTE = 8'h80;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_e;

   // Clear both bits of any contradictory pair
   function automatic logic [CMD_W-1:0] sanitise(input logic [CMD_W-1:0] c);
      logic [CMD_W-1:0] r;
      r = c;
      if (c[CMD_FWD] && c[CMD_BWD]) begin
         r[CMD_FWD] = 1'b0;
         r[CMD_BWD] = 1'b0;
      end
      if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
         r[CMD_LEFT]  = 1'b0;
         r[CMD_RIGHT] = 1'b0;
      end
      if (c[CMD_PLACE] && c[CMD_DESTROY]) begin
         r[CMD_PLACE]   = 1'b0;
         r[CMD_DESTROY] = 1'b0;
      end
      return r;
   endfunction

   // Index of the set bit in a one-hot requester vector (0 when none set)
   function automatic logic [IDX_W-1:0] oh_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/drive_req_picker.sv
// Combinational winner select among the drive requesters: fixed priority
// (requester 0 highest) or round robin starting after the last grantee.
module drive_req_picker
   import drive_cmd_pkg::*;
#(
   parameter int unsigned ROUND_ROBIN = 0
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner_oh_c,
   output logic               valid_c
);

   // Scan requesters in priority order and take the first one asserted
   always_comb begin
      logic             found;
      logic [IDX_W-1:0] idx;
      winner_oh_c = '0;
      valid_c     = |req;
      found       = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (ROUND_ROBIN != 0) idx = IDX_W'((32'(rr_ptr) + 32'd1 + k) % NUM_REQ);
         else                  idx = IDX_W'(k);
         if (!found && req[idx]) begin
            winner_oh_c[idx] = 1'b1;
            found            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Shares the single UART motion-command byte between the manual, semi-auto
// and auto/test drive requesters. One grant at a time, minimum hold before
// pre-emption, forced STOP gap on every hand-over, contradictory bits cleared.
// Optional build macro FWD_GUARD_EN: front_det masks the forward bit while granted.
module drive_cmd_arbiter
   import drive_cmd_pkg::*;
#(
   parameter int unsigned MIN_HOLD_CYC = 1000,
   parameter int unsigned GAP_CYC      = 100,
   parameter int unsigned ROUND_ROBIN  = 0
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic [2:0] req,
   input  logic [5:0] cmd0,
   input  logic [5:0] cmd1,
   input  logic [5:0] cmd2,
   input  logic       front_det,
   output logic [2:0] grant,
   output logic       busy,
   output logic [7:0] cmd_byte
);

   localparam int unsigned HOLD_W  = (MIN_HOLD_CYC == 0) ? 1 : $clog2(MIN_HOLD_CYC + 1);
   localparam int unsigned GAP_LEN = (GAP_CYC == 0) ? 1 : GAP_CYC;
   localparam int unsigned GAP_W   = $clog2(GAP_LEN + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD_CYC);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_LEN - 1);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                busy_q, busy_d;
   logic [7:0]          cmd_byte_q, cmd_byte_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]  win_oh_c;
   logic                win_valid_c;
   logic [CMD_W-1:0]    cmd_sel_c;
   logic [CMD_W-1:0]    cmd_clean_c;
   logic                owner_req_c;
   logic                higher_req_c;

   drive_req_picker #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_picker (
      .req         (req),
      .rr_ptr      (rr_ptr_q),
      .winner_oh_c (win_oh_c),
      .valid_c     (win_valid_c)
   );

   // Granted requester's command, sanitised and optionally collision-guarded
   always_comb begin
      case (oh_to_idx(grant_q))
         2'd0:    cmd_sel_c = cmd0;
         2'd1:    cmd_sel_c = cmd1;
         default: cmd_sel_c = cmd2;
      endcase
      cmd_clean_c = sanitise(cmd_sel_c);
`ifdef FWD_GUARD_EN
      if (front_det) cmd_clean_c[CMD_FWD] = 1'b0;
`endif
   end

`ifndef FWD_GUARD_EN
   logic unused_front_det;
   assign unused_front_det = front_det;
`endif

   // Owner still requesting, and any strictly higher-priority (lower index) request
   assign owner_req_c  = |(req & grant_q);
   assign higher_req_c = |(req & (grant_q - 3'd1));

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      cmd_byte_d = cmd_byte_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         ST_IDLE: begin
            grant_d    = '0;
            busy_d     = 1'b0;
            cmd_byte_d = STOP_BYTE;
            if (win_valid_c) begin
               state_d    = ST_GRANT;
               grant_d    = win_oh_c;
               busy_d     = 1'b1;
               hold_cnt_d = '0;
               rr_ptr_d   = oh_to_idx(win_oh_c);
            end
         end
         ST_GRANT: begin
            busy_d = 1'b1;
            if (!owner_req_c ||
                ((ROUND_ROBIN == 0) && higher_req_c && (hold_cnt_q == HOLD_MAX))) begin
               state_d    = ST_GAP;
               grant_d    = '0;
               cmd_byte_d = STOP_BYTE;
               gap_cnt_d  = '0;
            end else begin
               cmd_byte_d = {CMD_HDR, cmd_clean_c};
               if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         ST_GAP: begin
            grant_d    = '0;
            busy_d     = 1'b1;
            cmd_byte_d = STOP_BYTE;
            if (gap_cnt_q == GAP_LAST) begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            busy_d     = 1'b0;
            cmd_byte_d = STOP_BYTE;
         end
      endcase
   end

   // State and output registers, async active-low reset
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         cmd_byte_q <= STOP_BYTE;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         rr_ptr_q   <= IDX_W'(2);
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         cmd_byte_q <= cmd_byte_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign grant    = grant_q;
   assign busy     = busy_q;
   assign cmd_byte = cmd_byte_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Bench for drive_cmd_arbiter: a fixed-priority and a round-robin instance
// share stimulus; a behavioural model predicts both every cycle.
module tb_drive_cmd_arbiter;

   localparam int MIN_HOLD = 4;
   localparam int GAP      = 2;
   localparam int GAP_LEN  = (GAP == 0) ? 1 : GAP;
`ifdef FWD_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic       sys_clk = 1'b0;
   logic       rst;
   logic [2:0] req;
   logic [5:0] cmd0, cmd1, cmd2;
   logic       front_det;
   logic [2:0] grant_fp, grant_rr;
   logic       busy_fp, busy_rr;
   logic [7:0] cmd_fp, cmd_rr;

   int errors = 0;
   int checks = 0;

   always #5 sys_clk = ~sys_clk;

   drive_cmd_arbiter #(.MIN_HOLD_CYC(MIN_HOLD), .GAP_CYC(GAP), .ROUND_ROBIN(0)) u_fp (
      .sys_clk(sys_clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1), .cmd2(cmd2),
      .front_det(front_det), .grant(grant_fp), .busy(busy_fp), .cmd_byte(cmd_fp));

   drive_cmd_arbiter #(.MIN_HOLD_CYC(MIN_HOLD), .GAP_CYC(GAP), .ROUND_ROBIN(1)) u_rr (
      .sys_clk(sys_clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1), .cmd2(cmd2),
      .front_det(front_det), .grant(grant_rr), .busy(busy_rr), .cmd_byte(cmd_rr));

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 owned by m_owner, 2 stop gap; m_age counts edges in phase
   int         m_phase[2];
   int         m_owner[2];
   int         m_age[2];
   int         m_last[2];
   logic [2:0] e_grant[2];
   logic       e_busy[2];
   logic [7:0] e_cmd[2];

   function automatic logic [5:0] cmd_of(input int i);
      case (i)
         0:       return cmd0;
         1:       return cmd1;
         default: return cmd2;
      endcase
   endfunction

   function automatic logic [5:0] model_clean(input logic [5:0] c, input logic fd, input bit guard);
      logic [5:0] r;
      r = c;
      for (int p = 0; p < 3; p++) begin
         if (c[2*p] && c[2*p+1]) begin
            r[2*p]   = 1'b0;
            r[2*p+1] = 1'b0;
         end
      end
      if (guard && fd) r[0] = 1'b0;
      return r;
   endfunction

   function automatic int model_pick(input logic [2:0] r, input bit rr, input int last);
      if (!rr) begin
         for (int i = 0; i < 3; i++) if (r[i]) return i;
      end else begin
         for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
      end
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_phase[k] = 0;
      m_owner[k] = 0;
      m_age[k]   = 0;
      m_last[k]  = 2;
      e_grant[k] = 3'b000;
      e_busy[k]  = 1'b0;
      e_cmd[k]   = 8'h80;
   endtask

   task automatic model_step(input int k, input bit rr);
      int w;
      bit hi;
      case (m_phase[k])
         0: begin
            w = model_pick(req, rr, m_last[k]);
            e_cmd[k] = 8'h80;
            if (w >= 0) begin
               m_phase[k] = 1;
               m_owner[k] = w;
               m_age[k]   = 0;
               m_last[k]  = w;
               e_grant[k] = 3'(1 << w);
               e_busy[k]  = 1'b1;
            end else begin
               e_grant[k] = 3'b000;
               e_busy[k]  = 1'b0;
            end
         end
         1: begin
            hi = 1'b0;
            for (int i = 0; i < m_owner[k]; i++) if (req[i]) hi = 1'b1;
            e_busy[k] = 1'b1;
            if (!req[m_owner[k]] || (!rr && hi && m_age[k] >= MIN_HOLD)) begin
               m_phase[k] = 2;
               m_age[k]   = 0;
               e_grant[k] = 3'b000;
               e_cmd[k]   = 8'h80;
            end else begin
               m_age[k]++;
               e_cmd[k] = {2'b10, model_clean(cmd_of(m_owner[k]), front_det, GUARD)};
            end
         end
         default: begin
            e_grant[k] = 3'b000;
            e_cmd[k]   = 8'h80;
            if (m_age[k] + 1 >= GAP_LEN) begin
               m_phase[k] = 0;
               e_busy[k]  = 1'b0;
            end else begin
               m_age[k]++;
               e_busy[k] = 1'b1;
            end
         end
      endcase
   endtask

   always @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_step(0, 1'b0);
         model_step(1, 1'b1);
      end
   end

   // Per-cycle comparison of both instances against the model
   always @(negedge sys_clk) begin
      check("fp_grant", 8'(grant_fp), 8'(e_grant[0]));
      check("fp_busy",  8'(busy_fp),  8'(e_busy[0]));
      check("fp_cmd",   cmd_fp,       e_cmd[0]);
      check("rr_grant", 8'(grant_rr), 8'(e_grant[1]));
      check("rr_busy",  8'(busy_rr),  8'(e_busy[1]));
      check("rr_cmd",   cmd_rr,       e_cmd[1]);
   end

   // ---------------- directed and random stimulus ----------------
   initial begin
      logic [2:0] order [4];
      int zeros;
      order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

      rst = 1'b1; req = 3'b000; cmd0 = '0; cmd1 = '0; cmd2 = '0; front_det = 1'b0;
      #1 rst = 1'b0;
      #2;
      check("rst_grant", 8'(grant_fp), 8'h00);
      check("rst_busy",  8'(busy_fp),  8'h00);
      check("rst_cmd",   cmd_fp,       8'h80);
      repeat (2) @(negedge sys_clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge sys_clk);

      // single requester, latency and release
      #1 req = 3'b010; cmd1 = 6'b000001;
      @(negedge sys_clk);
      check("t2_grant", 8'(grant_fp), 8'h02);
      check("t2_cmd_first", cmd_fp, 8'h80);
      @(negedge sys_clk);
      check("t2_cmd", cmd_fp, 8'h81);
      #1 req = 3'b000;
      @(negedge sys_clk);
      check("t2_drop_grant", 8'(grant_fp), 8'h00);
      check("t2_drop_cmd", cmd_fp, 8'h80);
      check("t2_drop_busy", 8'(busy_fp), 8'h01);
      repeat (4) @(negedge sys_clk);
      check("t2_idle_busy", 8'(busy_fp), 8'h00);

      // pre-emption after the minimum hold
      #1 req = 3'b100; cmd2 = 6'b000010;
      @(negedge sys_clk);
      check("t3_grant2", 8'(grant_fp), 8'h04);
      @(negedge sys_clk);
      check("t3_cmd2", cmd_fp, 8'h82);
      #1 req = 3'b101;
      repeat (3) begin
         @(negedge sys_clk);
         check("t3_hold", 8'(grant_fp), 8'h04);
      end
      @(negedge sys_clk);
      check("t3_gap_grant", 8'(grant_fp), 8'h00);
      check("t3_gap_cmd", cmd_fp, 8'h80);
      @(negedge sys_clk);
      check("t3_gap2_grant", 8'(grant_fp), 8'h00);
      @(negedge sys_clk);
      check("t3_idle_grant", 8'(grant_fp), 8'h00);
      @(negedge sys_clk);
      check("t3_regrant0", 8'(grant_fp), 8'h01);
      check("t3_rr_kept", 8'(grant_rr), 8'h04);

      // sanitise
      #1 cmd0 = 6'b111111;
      @(negedge sys_clk);
      check("t4_all_bits", cmd_fp, 8'h80);
      #1 cmd0 = 6'b000110;
      @(negedge sys_clk);
      check("t4_left_back", cmd_fp, 8'h86);

      // asynchronous reset in the middle of a grant
      #2 rst = 1'b0;
      #1;
      check("t1_fp_grant", 8'(grant_fp), 8'h00);
      check("t1_fp_cmd",   cmd_fp,       8'h80);
      check("t1_fp_busy",  8'(busy_fp),  8'h00);
      check("t1_rr_grant", 8'(grant_rr), 8'h00);
      check("t1_rr_cmd",   cmd_rr,       8'h80);
      @(negedge sys_clk);
      #1 rst = 1'b1; req = 3'b111;

      // round-robin order with every grantee dropping in turn
      for (int n = 0; n < 4; n++) begin
         zeros = 0;
         do begin
            @(negedge sys_clk);
            if (grant_rr == 3'b000) zeros++;
            #1 req = 3'b111;
         end while (grant_rr == 3'b000 && zeros < 20);
         check("t5_rr_order", 8'(grant_rr), 8'(order[n]));
         if (n > 0) check("t5_rr_gap", 8'(zeros), 8'(GAP + 1));
         req = 3'b111 & ~grant_rr;
      end

      // forward collision guard
      #1 req = 3'b000;
      repeat (6) @(negedge sys_clk);
      #1 req = 3'b001; cmd0 = 6'b000101; front_det = 1'b1;
      @(negedge sys_clk);
      @(negedge sys_clk);
      check("t6_guard_on", cmd_fp, GUARD ? 8'h84 : 8'h85);
      #1 front_det = 1'b0;
      @(negedge sys_clk);
      check("t6_guard_off", cmd_fp, 8'h85);

      // random traffic, with one asynchronous reset pulse in the middle
      for (int c = 0; c < 3000; c++) begin
         @(negedge sys_clk);
         #1;
         for (int i = 0; i < 3; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         if ($urandom_range(0, 3) == 0) cmd0 = 6'($urandom);
         if ($urandom_range(0, 3) == 0) cmd1 = 6'($urandom);
         if ($urandom_range(0, 3) == 0) cmd2 = 6'($urandom);
         front_det = ($urandom_range(0, 3) == 0);
         if (c == 1500) begin
            #2 rst = 1'b0;
            #1 rst = 1'b1;
         end
      end

      @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
